// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the parametrised Viterbi decoder: FSM states,
// parity, and the encoder's expected-symbol function used to build branch labels.
package viterbi_pkg;

    typedef enum logic [1:0] {
        S_ACS,
        S_TB,
        S_OUT
    } state_e;

    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

    // Expected {c0,c1} for input bit u leaving state s of a K-stage encoder.
    function automatic logic [1:0] exp_sym(input int k, input int g0, input int g1,
                                           input int u, input int s);
        logic [31:0] r;
        r = 32'((u << (k - 1)) | s);
        return {parity(r & 32'(g0)), parity(r & 32'(g1))};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Single-state add-compare-select: saturating metric adds, ties resolve to the
// even predecessor, dec_o flags selection of the odd predecessor.
module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter int         PM_W = 5,
    parameter logic [1:0] EXP0 = 2'b00,
    parameter logic [1:0] EXP1 = 2'b00
) (
    input  logic [1:0]      sym_i,
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);

    logic [PM_W:0]   sum0, sum1;
    logic [PM_W-1:0] cand0, cand1;

    always_comb begin
        sum0  = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, hamming2(sym_i, EXP0)};
        sum1  = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, hamming2(sym_i, EXP1)};
        cand0 = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
        cand1 = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
        dec_o = (cand1 < cand0);
        pm_o  = dec_o ? cand1 : cand0;
    end

endmodule

// File: rtl/viterbi_decoder_param.sv
// Hard-decision rate-1/2 zero-tail Viterbi decoder, one symbol per cycle ACS,
// register-array survivors, serial traceback. Define VITERBI_ERRCNT_EN for o_errcnt.
//
// state | meaning
// S_ACS | accepting symbols, one ACS step per handshake
// S_TB  | tracing back one survivor row per cycle from state 0
// S_OUT | publish o_data / o_done, reinitialise metrics
module viterbi_decoder_param
    import viterbi_pkg::*;
#(
    parameter int           K         = 3,
    parameter logic [K-1:0] G0        = 3'b111,
    parameter logic [K-1:0] G1        = 3'b101,
    parameter int           FRAME_LEN = 10,
    localparam int          MSG_LEN   = FRAME_LEN - K + 1,
    localparam int          PM_W      = $clog2(2 * FRAME_LEN + 2)
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_sym,
    output logic [MSG_LEN-1:0] o_data,
    output logic               o_done
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [PM_W-1:0]    o_errcnt
`endif
);

    localparam int NS = 2 ** (K - 1);
    localparam int SW = K - 1;
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0]   LAST   = CW'(FRAME_LEN - 1);
    localparam logic [PM_W-1:0] PM_SAT = {PM_W{1'b1}};

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      tb_s_q, tb_s_d;
    logic [MSG_LEN-1:0] msg_q, msg_d;
    logic [MSG_LEN-1:0] data_q, data_d;
    logic               done_q, done_d;
    logic [PM_W-1:0]    pm_q [NS];
    logic [PM_W-1:0]    pm_d [NS];
    logic [PM_W-1:0]    acs_pm [NS];
    logic [NS-1:0]      dec;
    logic [NS-1:0]      surv_q [FRAME_LEN];
    logic               acc;
`ifdef VITERBI_ERRCNT_EN
    logic [PM_W-1:0]    errcnt_q, errcnt_d;
`endif

    assign o_ready = (state_q == S_ACS);
    assign acc     = i_valid & o_ready;
    assign o_data  = data_q;
    assign o_done  = done_q;
`ifdef VITERBI_ERRCNT_EN
    assign o_errcnt = errcnt_q;
`endif

    // Branch labels are fixed by the generators, so they become ACS parameters.
    for (genvar n = 0; n < NS; n++) begin : g_acs
        localparam int P0 = (2 * n) % NS;
        localparam int U  = n >> (K - 2);
        localparam logic [1:0] E0 = exp_sym(K, int'(G0), int'(G1), U, P0);
        localparam logic [1:0] E1 = exp_sym(K, int'(G0), int'(G1), U, P0 + 1);

        viterbi_acs_unit #(
            .PM_W (PM_W),
            .EXP0 (E0),
            .EXP1 (E1)
        ) u_acs (
            .sym_i (i_sym),
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P0+1]),
            .pm_o  (acs_pm[n]),
            .dec_o (dec[n])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tb_s_d  = tb_s_q;
        msg_d   = msg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        pm_d    = pm_q;
`ifdef VITERBI_ERRCNT_EN
        errcnt_d = errcnt_q;
`endif
        case (state_q)
            S_ACS: begin
                if (i_valid) begin
                    pm_d = acs_pm;
                    if (cnt_q == LAST) begin
                        state_d = S_TB;
                        tb_s_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_TB: begin
                for (int i = 0; i < MSG_LEN; i++) begin
                    if (cnt_q == CW'(i)) msg_d[i] = tb_s_q[SW-1];
                end
                tb_s_d = {tb_s_q[SW-2:0], surv_q[cnt_q][tb_s_q]};
                if (cnt_q == '0) state_d = S_OUT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_OUT: begin
                data_d  = msg_q;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_ACS;
`ifdef VITERBI_ERRCNT_EN
                errcnt_d = pm_q[0];
`endif
                for (int i = 0; i < NS; i++) pm_d[i] = (i == 0) ? '0 : PM_SAT;
            end
            default: state_d = S_ACS;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ACS;
            cnt_q   <= '0;
            tb_s_q  <= '0;
            msg_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NS; i++) pm_q[i] <= (i == 0) ? '0 : PM_SAT;
`ifdef VITERBI_ERRCNT_EN
            errcnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tb_s_q  <= tb_s_d;
            msg_q   <= msg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            pm_q    <= pm_d;
`ifdef VITERBI_ERRCNT_EN
            errcnt_q <= errcnt_d;
`endif
        end
    end

    // Rows are always rewritten before traceback reads them, so no reset needed.
    always_ff @(posedge sys_clk) begin
        if (acc) surv_q[cnt_q] <= dec;
    end

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// Directed bench for viterbi_decoder_param: default K=3 instance plus a K=5,
// FRAME_LEN=36 instance fed by a bench-side convolutional encoder.
module tb_viterbi_decoder_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   cur = 0;
    logic valid = 1'b0;
    logic [1:0] sym = 2'b00;

    logic        a_valid, a_ready, a_done;
    logic [7:0]  a_data;
    logic        b_valid, b_ready, b_done;
    logic [31:0] b_data;
`ifdef VITERBI_ERRCNT_EN
    logic [4:0]  a_err;
    logic [6:0]  b_err;
`endif

    assign a_valid = (cur == 0) && valid;
    assign b_valid = (cur == 1) && valid;

    viterbi_decoder_param u_dut_a (
        .sys_clk  (clk),
        .rst      (rst),
        .i_valid  (a_valid),
        .o_ready  (a_ready),
        .i_sym    (sym),
        .o_data   (a_data),
        .o_done   (a_done)
`ifdef VITERBI_ERRCNT_EN
        ,
        .o_errcnt (a_err)
`endif
    );

    viterbi_decoder_param #(
        .K         (5),
        .G0        (5'b10011),
        .G1        (5'b11101),
        .FRAME_LEN (36)
    ) u_dut_b (
        .sys_clk  (clk),
        .rst      (rst),
        .i_valid  (b_valid),
        .o_ready  (b_ready),
        .i_sym    (sym),
        .o_data   (b_data),
        .o_done   (b_done)
`ifdef VITERBI_ERRCNT_EN
        ,
        .o_errcnt (b_err)
`endif
    );

    logic        rdy, done;
    logic [31:0] cur_data;
    assign rdy      = (cur == 1) ? b_ready : a_ready;
    assign done     = (cur == 1) ? b_done  : a_done;
    assign cur_data = (cur == 1) ? b_data  : {24'd0, a_data};
`ifdef VITERBI_ERRCNT_EN
    logic [6:0] cur_err;
    assign cur_err = (cur == 1) ? b_err : {2'b00, a_err};
`endif

    int a_done_cnt = 0;
    always @(posedge clk) if (a_done) a_done_cnt <= a_done_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int t_acc = 0;
    logic [1:0] sy [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: register {u,s}, next state is the register shifted right.
    task automatic encode(input int k, input int g0, input int g1,
                          input logic [31:0] msg, input int flen);
        int s;
        int r;
        int u;
        s = 0;
        for (int t = 0; t < flen; t++) begin
            u = (t < flen - k + 1) ? int'(msg[t]) : 0;
            r = (u << (k - 1)) | s;
            sy[t] = {^(r & g0), ^(r & g1)};
            s = r >> 1;
        end
    endtask

    task automatic send(input logic [1:0] s);
        int n;
        n = 0;
        sym   = s;
        valid = 1'b1;
        while (!rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("send_ready_timeout", 64'(rdy), 64'd1);
        @(posedge clk); #1;
        t_acc = cyc;
        valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int flen, input bit stall,
                             input bit offer, input logic [31:0] exp_data, input int exp_err);
        int n;
        for (int t = 0; t < flen; t++) begin
            if (stall) begin
                valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            send(sy[t]);
        end
        if (offer) begin
            sym   = 2'b11;
            valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                chk({tag, "_tb_ready"}, 64'(rdy), 64'd0);
                @(posedge clk); #1;
            end
            valid = 1'b0;
        end
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_latency"}, 64'(cyc - t_acc), 64'(flen + 1));
        chk({tag, "_data"}, 64'(cur_data), 64'(exp_data));
`ifdef VITERBI_ERRCNT_EN
        chk({tag, "_errcnt"}, 64'(cur_err), 64'(exp_err));
`else
        if (exp_err < 0) $display("note: negative error expectation in %s", tag);
`endif
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_data_hold"}, 64'(cur_data), 64'(exp_data));
    endtask

    initial begin
        int snap;
        logic [31:0] m;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_a_ready", 64'(a_ready), 64'd1);
        chk("rst_a_done",  64'(a_done),  64'd0);
        chk("rst_a_data",  64'(a_data),  64'd0);
        chk("rst_b_ready", 64'(b_ready), 64'd1);
        chk("rst_b_data",  64'(b_data),  64'd0);
`ifdef VITERBI_ERRCNT_EN
        chk("rst_a_err", 64'(a_err), 64'd0);
`endif

        cur = 0;
        for (int t = 0; t < 10; t++) sy[t] = 2'b00;
        run_frame("a_zero", 10, 1'b0, 1'b0, 32'h00, 0);

        sy[0] = 2'b11; sy[1] = 2'b10; sy[2] = 2'b11;
        run_frame("a_impulse", 10, 1'b0, 1'b0, 32'h01, 0);

        sy[3] = 2'b01;
        run_frame("a_impulse_err", 10, 1'b0, 1'b0, 32'h01, 1);

        encode(3, 7, 5, 32'hB4, 10);
        run_frame("a_b4_stall", 10, 1'b1, 1'b1, 32'hB4, 0);

        encode(3, 7, 5, 32'h5A, 10);
        sy[6] = sy[6] ^ 2'b10;
        run_frame("a_5a_err", 10, 1'b0, 1'b0, 32'h5A, 1);

        encode(3, 7, 5, 32'h3C, 10);
        for (int t = 0; t < 5; t++) send(sy[t]);
        snap = a_done_cnt;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_data",  64'(a_data),  64'd0);
        chk("abort_ready", 64'(a_ready), 64'd1);
        repeat (15) begin @(posedge clk); #1; end
        chk("abort_no_done", 64'(a_done_cnt), 64'(snap));

        sy[0] = 2'b11; sy[1] = 2'b10; sy[2] = 2'b11;
        for (int t = 3; t < 10; t++) sy[t] = 2'b00;
        run_frame("a_fresh", 10, 1'b0, 1'b0, 32'h01, 0);

        cur = 1;
        m = $urandom();
        encode(5, 5'b10011, 5'b11101, m, 36);
        run_frame("b_clean", 36, 1'b0, 1'b0, m, 0);

        m = $urandom();
        encode(5, 5'b10011, 5'b11101, m, 36);
        sy[4]  = sy[4]  ^ 2'b10;
        sy[13] = sy[13] ^ 2'b01;
        sy[22] = sy[22] ^ 2'b10;
        sy[31] = sy[31] ^ 2'b01;
        run_frame("b_err4", 36, 1'b0, 1'b0, m, 4);

        m = $urandom();
        encode(5, 5'b10011, 5'b11101, m, 36);
        sy[2]  = sy[2]  ^ 2'b01;
        sy[20] = sy[20] ^ 2'b10;
        run_frame("b_stall", 36, 1'b1, 1'b1, m, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/viterbi_decoder_param.md
# viterbi_decoder_param

Parametrised hard-decision Viterbi decoder for rate-1/2 terminated (zero-tail) convolutional frames, with configurable constraint length, generator polynomials and frame length. It is the next generation of the fixed K=3 datapath (extract → branch metric → ACS → survivor memory → traceback). It takes a valid/ready stream of 2-bit code symbols, runs all-state ACS at one symbol per cycle, and stores survivor decisions. After the last symbol it traces back from state 0 and presents the decoded message as a parallel word with a done pulse.

## Interface
- K, 3, constraint length, legal range 3..7; NS = 2^(K-1) states
- G0, 3'b111, generator polynomial for symbol bit 1, K bits wide
- G1, 3'b101, generator polynomial for symbol bit 0, K bits wide
- FRAME_LEN, 10, symbols per frame, including K-1 tail symbols; must be greater than K-1
- MSG_LEN, FRAME_LEN-K+1, localparam, number of decoded message bits
- PM_W, $clog2(2*FRAME_LEN+2), localparam, path-metric width
- sys_clk  in  1  clock; one clock domain, rising edge
- rst  in  1  asynchronous active-high reset
- i_valid  in  1  input symbol valid
- o_ready  out  1  decoder can accept a symbol
- i_sym  in  2  code symbol, [1]=c0 (G0), [0]=c1 (G1)
- o_data  out  MSG_LEN  decoded message; bit 0 is the first transmitted message bit
- o_done  out  1  one-cycle pulse; o_data is valid from this cycle
- o_errcnt  out  PM_W  final state-0 path metric (present only with VITERBI_ERRCNT_EN)

## Operation
- Encoder convention:
  - register {u, s}, where s is the (K-1)-bit state
  - c0 = ^({u,s} & G0), c1 = ^({u,s} & G1)
  - next state = {u, s[K-2:1]}
- Branch metric: Hamming distance (0..2) between i_sym and the expected {c0,c1}.
- ACS, for each next state n:
  - u = n[K-2]
  - predecessors p0 = {n[K-3:0],0} and p1 = {n[K-3:0],1}
  - candidate metrics are computed with saturating adds at 2^PM_W-1
  - select p1 only if its metric is strictly smaller; ties select p0
  - survivor bit = 1 when p1 is selected
- Metric init at frame start: state 0 = 0, all other states = 2^PM_W-1 (saturated).
- Survivor memory: FRAME_LEN × NS bits, written at row t = symbol index.
- Traceback:
  - start at s = 0
  - for t = FRAME_LEN-1 down to 0: bit_t = s[K-2], then s = {s[K-3:0], surv[t][s]}
  - bits with t < MSG_LEN are written into o_data[t]; tail bits are discarded
- FSM:
  - S_ACS: o_ready=1; each handshake (i_valid & o_ready) does one ACS step and increments the symbol counter; after symbol FRAME_LEN-1 → S_TB
  - S_TB: o_ready=0; one traceback step per cycle for FRAME_LEN cycles → S_OUT
  - S_OUT: o_done=1 for one cycle, o_data updated, metrics and counters reinitialised → S_ACS
- No metric normalisation is needed: the worst-case metric 2*FRAME_LEN fits in PM_W.

## Timing
- Reset values:
  - state S_ACS, o_ready=1 one cycle after reset release
  - o_data=0, o_done=0, o_errcnt=0
  - metrics at init values, counters 0
- Handshake occurs when i_valid & o_ready at a sys_clk edge. i_valid low stalls decoding with no state change.
- Latency: if the last symbol is accepted at edge T, o_done is high in the cycle after edge T+FRAME_LEN+1.
- The next frame's first symbol is accepted no earlier than the cycle after o_done.
- o_data and o_errcnt hold their values until the next o_done.
- Minimum frame period is 2*FRAME_LEN+1 cycles at a 100% valid duty.
- i_valid while o_ready=0 is ignored; the symbol is not consumed.
- Reset asserted mid-frame or mid-traceback aborts the frame with no o_done. All state returns to reset values.

## Configuration
- VITERBI_ERRCNT_EN defined:
  - o_errcnt port exists
  - it is loaded in S_OUT with the state-0 path metric, i.e. the number of channel bit errors corrected on the chosen path
- VITERBI_ERRCNT_EN undefined: the port and its register are absent, and decoding behaviour is identical.

## Structure
- Package viterbi_pkg holds:
  - the FSM state enum (S_ACS, S_TB, S_OUT)
  - a parity function
  - the expected-symbol function exp_sym(K, G0, G1, u, s)
- One sub-module, viterbi_acs_unit: a single-state add-compare-select, instantiated NS times via generate.
- Survivor memory is an inferred register array in the top block.

## Test plan
- Default params, 10 symbols of 00 → o_data=8'h00, o_errcnt=0, o_done exactly FRAME_LEN+1 cycles after the last accept.
- Impulse message (first bit 1): symbols 11,10,11, then 7×00 → o_data=8'h01, o_errcnt=0.
- Impulse frame with symbol 4 corrupted to 01 → o_data=8'h01, o_errcnt=1.
- Random messages encoded by the bench reference model, K=5 (G0=5'b10011, G1=5'b11101), FRAME_LEN=36 with ≤1 error per 5-symbol window → o_data matches the message.
- i_valid toggled randomly, plus a symbol offered during S_TB → o_ready=0 and the symbol is not consumed; the result is unchanged.
- Reset pulsed after 5 symbols, then a full fresh frame → no o_done for the aborted frame; the fresh frame decodes correctly.
